// File: rtl/pc_next_unit.sv
// Program-counter stage: holds the PC, selects the next fetch address and
// runs a BOOT/RUN/HALT/FAULT FSM that stops fetch on halt or an illegal target.
module pc_next_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 128,
  parameter logic [5:0]  HALT_OP    = 6'b111111
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [5:0]  op,
  input  logic [15:0] Immediate,
  input  logic [31:0] JumpPC,
  input  logic [31:0] RegPC,
  output logic [31:0] IAddr,
  output logic [31:0] PC4,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  state,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    HALT  = 2'b10,
    FAULT = 2'b11
  } st_t;

  localparam logic [31:0] PC_MAX = 32'(IMEM_BYTES - 4);

  st_t         cur_st, nxt_st;
  logic [31:0] target;
  logic        illegal;
  logic        pc_en;

  assign PC4   = IAddr + 32'd4;
  assign state = cur_st;

  always_comb begin
    target = PC4;
    unique case (PCSrc)
      2'b00: target = PC4;
      2'b01: target = PC4 + {{14{Immediate[15]}}, Immediate, 2'b00};
      2'b10: target = JumpPC;
      2'b11: target = RegPC;
    endcase
  end

  // Running off the top of memory is treated as a fault, never a wrap to 0.
  assign illegal = (target[1:0] != 2'b00) || (target > PC_MAX);

  always_comb begin
    nxt_st = cur_st;
    pc_en  = 1'b0;
    unique case (cur_st)
      BOOT: nxt_st = RUN;
      RUN: begin
        if (op == HALT_OP)  nxt_st = HALT;
        else if (!PCWre)    nxt_st = RUN;
        else if (illegal)   nxt_st = FAULT;
        else                pc_en  = 1'b1;
      end
      HALT:  nxt_st = HALT;
      FAULT: nxt_st = FAULT;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cur_st      <= BOOT;
      IAddr       <= RESET_PC;
      instr_count <= 32'd0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      cur_st <= nxt_st;
      halted <= (nxt_st == HALT);
      fault  <= (nxt_st == FAULT);
      if (pc_en) begin
        IAddr       <= target;
        instr_count <= instr_count + 32'd1;
      end
    end
  end

endmodule
